// File: rtl/bit_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// bit_serial_adder_pkg
//   Shared definitions for the bit-serial adder slice.
//   - state_t : FSM state encoding (IDLE / SHIFT / DONE)
//   - ADDER_W : default operand/sum width
// ---------------------------------------------------------------------------
package bit_serial_adder_pkg;

    // Encoding is fixed so other blocks and waveforms can decode it directly
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int ADDER_W = 8;

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   Single-bit full adder cell.
//   Ports:
//     x, y : input  addend bits
//     z    : input  carry-in
//     s    : output sum bit
//     c    : output carry-out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    // Sum is the parity of the three inputs, carry is their majority
    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/bit_serial_adder.sv
// ---------------------------------------------------------------------------
// bit_serial_adder
//   N-bit adder that pushes one bit per clock through a single full_adder.
//   Operands are captured on an accepted start, shifted out LSB first, and
//   the sum bits are shifted into a result register from the top.
//   Ports:
//     clk   : input  clock, all state updates on rising edge
//     rst_n : input  asynchronous active-low reset
//     start : input  request, only looked at in IDLE
//     a, b  : input  N-bit operands, captured on accepted start
//     cin   : input  carry-in, captured on accepted start
//     busy  : output high while bits are being shifted
//     done  : output one-cycle pulse, sum/cout valid from this cycle
//     sum   : output registered N-bit result, held until next completion
//     cout  : output registered carry-out, held with sum
// ---------------------------------------------------------------------------
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int N = ADDER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    // One extra bit so that cnt == N-1 can never alias for any legal N
    localparam int CW = $clog2(N) + 1;

    state_t         state;
    state_t         state_next;

    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [N-1:0]   s_r;
    logic           carry;
    logic [CW-1:0]  cnt;

    logic           fa_s;
    logic           fa_c;
    logic [N-1:0]   s_shift;
    logic           last_bit;

    // The single adder cell, fed from the bottom of the operand registers
    full_adder u_full_adder (
        .x (a_r[0]),
        .y (b_r[0]),
        .z (carry),
        .s (fa_s),
        .c (fa_c)
    );

    // New sum bit enters at the MSB; with N=1 the register is just that bit
    generate
        if (N == 1) begin : g_single
            assign s_shift = fa_s;
        end else begin : g_multi
            assign s_shift = {fa_s, s_r[N-1:1]};
        end
    endgenerate

    assign last_bit = (cnt == CW'(N - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: SHIFT runs N edges, DONE is a single-cycle pulse,
    // and start is only honoured from IDLE so requests are never queued
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:                  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Datapath: capture operands on start, then shift one bit per edge.
    // sum/cout are only written on the final bit so the previous result
    // stays visible through the whole next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            s_r   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        s_r   <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_r   <= a_r >> 1;
                    b_r   <= b_r >> 1;
                    s_r   <= s_shift;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= s_shift;
                        cout <= fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decode straight from the registered state
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_adder
//   Self-checking bench for bit_serial_adder at N=8 and N=1. Expected
//   results come from plain integer addition of the captured operands.
// ---------------------------------------------------------------------------
module tb_bit_serial_adder;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         cin1;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         cout1;

    int           checks = 0;
    int           errors = 0;

    logic [N-1:0] held_sum  = '0;
    logic         held_cout = 1'b0;

    always #5 clk = ~clk;

    bit_serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    bit_serial_adder #(.N(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Run one N=8 operation starting at a negedge. Optionally pokes start
    // during SHIFT and during DONE to confirm those requests are dropped.
    // Returns at the negedge after the cycle following done.
    task automatic applyStimulus(input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                                 input logic op_cin, input bit poke_busy, input bit poke_done);
        logic [N:0] expected;
        int         cycles;
        int         busy_seen;
        bit         seen;

        expected = {1'b0, op_a} + {1'b0, op_b} + {{N{1'b0}}, op_cin};

        start = 1'b1;
        a     = op_a;
        b     = op_b;
        cin   = op_cin;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        cin   = 1'($urandom);

        cycles    = 0;
        busy_seen = 0;
        seen      = 1'b0;
        while (!seen && cycles < 40) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_seen++;
                checkOutput("hold_sum", {63'd0, sum} , {63'd0, held_sum});
                checkOutput("hold_cout", {63'd0, cout}, {63'd0, held_cout});
                if (poke_busy && cycles == 2) begin
                    start = 1'b1;
                    a     = 8'h01;
                    b     = 8'h01;
                end else if (poke_busy && cycles == 3) begin
                    start = 1'b0;
                end
                @(posedge clk);
                cycles++;
                @(negedge clk);
            end
        end
        start = 1'b0;

        checkOutput("latency", cycles, N);
        checkOutput("busy_cycles", busy_seen, N);
        checkOutput("busy_in_done", {63'd0, busy}, 0);
        checkOutput("sum", {56'd0, sum}, {56'd0, expected[N-1:0]});
        checkOutput("cout", {63'd0, cout}, {63'd0, expected[N]});
        held_sum  = expected[N-1:0];
        held_cout = expected[N];

        if (poke_done) begin
            start = 1'b1;
            a     = 8'h01;
            b     = 8'h01;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_pulse", {63'd0, done}, 0);
        checkOutput("idle_busy", {63'd0, busy}, 0);
        checkOutput("idle_sum", {56'd0, sum}, {56'd0, held_sum});
    endtask

    // Run one N=1 operation and check the one-clock latency and result
    task automatic applyStimulusOne(input logic op_a, input logic op_b, input logic op_cin);
        int total;
        total  = int'(op_a) + int'(op_b) + int'(op_cin);
        start1 = 1'b1;
        a1     = op_a;
        b1     = op_b;
        cin1   = op_cin;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        a1     = 1'($urandom);
        b1     = 1'($urandom);
        cin1   = 1'($urandom);
        checkOutput("n1_busy", {63'd0, busy1}, 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("n1_done", {63'd0, done1}, 1);
        checkOutput("n1_sum", {63'd0, sum1}, total % 2);
        checkOutput("n1_cout", {63'd0, cout1}, total / 2);
        @(posedge clk);
        @(negedge clk);
        checkOutput("n1_done_pulse", {63'd0, done1}, 0);
    endtask

    initial begin
        int done_seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;

        #1;
        checkOutput("reset_busy", {63'd0, busy}, 0);
        checkOutput("reset_done", {63'd0, done}, 0);
        checkOutput("reset_sum", {56'd0, sum}, 0);
        checkOutput("reset_cout", {63'd0, cout}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed N=8 cases");
        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b1, 1'b1);

        $display("[TB] reset during SHIFT");
        start = 1'b1;
        a     = 8'hC3;
        b     = 8'h71;
        cin   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_reset_busy", {63'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_busy", {63'd0, busy}, 0);
        checkOutput("mid_reset_done", {63'd0, done}, 0);
        checkOutput("mid_reset_sum", {56'd0, sum}, 0);
        checkOutput("mid_reset_cout", {63'd0, cout}, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        held_sum  = '0;
        held_cout = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        checkOutput("no_done_after_reset", done_seen, 0);
        applyStimulus(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);

        $display("[TB] random N=8 cases");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(N'($urandom), N'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom));
        end

        $display("[TB] N=1 cases");
        applyStimulusOne(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulusOne(1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
